// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg -- shared definitions for the parameterised reservation station.
//
// Holds the default geometry (entry count, CDB channel count and field
// widths). It also holds the reference entry layout at those default widths,
// which is useful for debug taps and for models that want the same packing.
//
// Optional feature macro used by the station:
//   RS_CDB_BYPASS_EN  -- capture same-cycle CDB broadcasts on insertion.
// -----------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_DEPTH   = 4;
    localparam int RS_NUM_CDB = 4;
    localparam int RS_TAG_W   = 4;
    localparam int RS_DATA_W  = 16;
    localparam int RS_OPC_W   = 4;
    localparam int RS_IMM_W   = 8;

    // One station slot at the default widths.
    typedef struct packed {
        logic                 valid;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_OPC_W-1:0]  opcode;
        logic [RS_IMM_W-1:0]  imm;
        logic [RS_TAG_W-1:0]  src1_tag;
        logic [RS_DATA_W-1:0] src1_val;
        logic                 src1_rdy;
        logic [RS_TAG_W-1:0]  src2_tag;
        logic [RS_DATA_W-1:0] src2_val;
        logic                 src2_rdy;
    } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// -----------------------------------------------------------------------------
// rs_entry -- one reservation station slot.
//
// Stores one dispatched instruction and snoops the common data bus for the
// operands that are still outstanding. When several channels carry the wanted
// tag, the lowest channel index wins.
//
// Optional macro RS_CDB_BYPASS_EN: when an operand is loaded as not ready and
// a valid CDB channel broadcasts its tag in the same cycle, the operand is
// stored as ready with that data. Without the macro, loaded operands are
// stored exactly as presented.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous squash (clears valid)
//   load               write the in_* fields into this slot (slot must be free)
//   issue              slot was selected for issue this cycle (frees it)
//   in_*               instruction fields being dispatched
//   cdb_valid/tag/data flat CDB broadcast, channel k at slice k
//   valid              slot occupied
//   ready              slot occupied and both operands available
//   tag..val2          stored instruction fields
// -----------------------------------------------------------------------------
module rs_entry
    import rs_pkg::*;
#(
    parameter int NUM_CDB = RS_NUM_CDB,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OPC_W   = RS_OPC_W,
    parameter int IMM_W   = RS_IMM_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      load,
    input  logic                      issue,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [OPC_W-1:0]          in_opcode,
    input  logic [IMM_W-1:0]          in_imm,
    input  logic [TAG_W-1:0]          in_src1_tag,
    input  logic [TAG_W-1:0]          in_src2_tag,
    input  logic [DATA_W-1:0]         in_src1_val,
    input  logic [DATA_W-1:0]         in_src2_val,
    input  logic                      in_src1_rdy,
    input  logic                      in_src2_rdy,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      valid,
    output logic                      ready,
    output logic [TAG_W-1:0]          tag,
    output logic [OPC_W-1:0]          opcode,
    output logic [IMM_W-1:0]          imm,
    output logic [DATA_W-1:0]         val1,
    output logic [DATA_W-1:0]         val2
);

    // Returns {hit, data}; channels are scanned high to low so the lowest
    // matching channel is the one left in the result.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          t,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == t)) begin
                r = {1'b1, data[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    logic              valid_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [OPC_W-1:0]  opcode_reg;
    logic [IMM_W-1:0]  imm_reg;
    logic [TAG_W-1:0]  op_tag_reg [2];
    logic [DATA_W-1:0] op_val_reg [2];
    logic [1:0]        op_rdy_reg;

    // Dispatched operand fields, indexed by operand number.
    logic [TAG_W-1:0]  src_tag [2];
    logic [DATA_W-1:0] src_val [2];
    logic [1:0]        src_rdy;

    logic [DATA_W:0]   wake_lk [2];
    logic [1:0]        load_rdy;
    logic [DATA_W-1:0] load_val [2];

    assign src_tag[0] = in_src1_tag;
    assign src_tag[1] = in_src2_tag;
    assign src_val[0] = in_src1_val;
    assign src_val[1] = in_src2_val;
    assign src_rdy    = {in_src2_rdy, in_src1_rdy};

`ifdef RS_CDB_BYPASS_EN
    logic [DATA_W:0] byp_lk [2];
`endif

    always_comb begin
        for (int op = 0; op < 2; op++) begin
            wake_lk[op] = cdb_lookup(op_tag_reg[op], cdb_valid, cdb_tag, cdb_data);
`ifdef RS_CDB_BYPASS_EN
            byp_lk[op]   = cdb_lookup(src_tag[op], cdb_valid, cdb_tag, cdb_data);
            load_rdy[op] = src_rdy[op] | byp_lk[op][DATA_W];
            load_val[op] = (!src_rdy[op] && byp_lk[op][DATA_W]) ?
                           byp_lk[op][DATA_W-1:0] : src_val[op];
`else
            load_rdy[op] = src_rdy[op];
            load_val[op] = src_val[op];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            tag_reg    <= '0;
            opcode_reg <= '0;
            imm_reg    <= '0;
            op_rdy_reg <= '0;
            for (int op = 0; op < 2; op++) begin
                op_tag_reg[op] <= '0;
                op_val_reg[op] <= '0;
            end
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (load) begin
                valid_reg <= 1'b1;
            end else if (issue) begin
                valid_reg <= 1'b0;
            end

            if (load) begin
                tag_reg    <= in_tag;
                opcode_reg <= in_opcode;
                imm_reg    <= in_imm;
            end

            for (int op = 0; op < 2; op++) begin
                if (load) begin
                    op_tag_reg[op] <= src_tag[op];
                    op_rdy_reg[op] <= load_rdy[op];
                    op_val_reg[op] <= load_val[op];
                end else if (valid_reg && !op_rdy_reg[op] && wake_lk[op][DATA_W]) begin
                    op_rdy_reg[op] <= 1'b1;
                    op_val_reg[op] <= wake_lk[op][DATA_W-1:0];
                end
            end
        end
    end

    assign valid  = valid_reg;
    assign ready  = valid_reg & op_rdy_reg[0] & op_rdy_reg[1];
    assign tag    = tag_reg;
    assign opcode = opcode_reg;
    assign imm    = imm_reg;
    assign val1   = op_val_reg[0];
    assign val2   = op_val_reg[1];

endmodule

// File: rtl/param_res_station.sv
// -----------------------------------------------------------------------------
// param_res_station -- parameterised reservation station with oldest-ready
// issue.
//
// Instructions are dispatched into the lowest free slot. Each slot snoops the
// CDB for missing operands. An age matrix picks the oldest slot whose operands
// are both ready, and that slot is moved into a single output register that
// feeds the functional unit through a valid/ready handshake.
//
// Optional macro RS_CDB_BYPASS_EN (handled in rs_entry): on insertion, capture
// a same-cycle CDB broadcast for an operand that arrives not ready.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        dispatch handshake
//   in_tag/opcode/imm        dispatched instruction
//   in_src{1,2}_tag/val/rdy  operand producer tag, value, value-valid
//   cdb_valid/tag/data       NUM_CDB broadcast channels, flat, channel 0 at LSB
//   flush                    synchronous squash of entries and output register
//   out_valid/out_ready      issue handshake
//   out_tag..out_val2        issued instruction
//   count                    occupied slots (output register not included)
// -----------------------------------------------------------------------------
module param_res_station
    import rs_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int NUM_CDB = RS_NUM_CDB,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OPC_W   = RS_OPC_W,
    parameter int IMM_W   = RS_IMM_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [OPC_W-1:0]          in_opcode,
    input  logic [IMM_W-1:0]          in_imm,
    input  logic [TAG_W-1:0]          in_src1_tag,
    input  logic [TAG_W-1:0]          in_src2_tag,
    input  logic [DATA_W-1:0]         in_src1_val,
    input  logic [DATA_W-1:0]         in_src2_val,
    input  logic                      in_src1_rdy,
    input  logic                      in_src2_rdy,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output logic [OPC_W-1:0]          out_opcode,
    output logic [IMM_W-1:0]          out_imm,
    output logic [DATA_W-1:0]         out_val1,
    output logic [DATA_W-1:0]         out_val2,
    output logic [CNT_W-1:0]          count
);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_ready;
    logic [TAG_W-1:0]  ent_tag    [DEPTH];
    logic [OPC_W-1:0]  ent_opcode [DEPTH];
    logic [IMM_W-1:0]  ent_imm    [DEPTH];
    logic [DATA_W-1:0] ent_val1   [DEPTH];
    logic [DATA_W-1:0] ent_val2   [DEPTH];

    logic [DEPTH-1:0]  free_onehot;
    logic [DEPTH-1:0]  load_vec;
    logic [DEPTH-1:0]  grant;
    logic [DEPTH-1:0]  issue_vec;
    logic              in_fire;
    logic              issue_fire;

    // older_reg[i][j] = 1 means slot i was written before slot j.
    logic [DEPTH-1:0]  older_reg [DEPTH];

    logic [CNT_W-1:0]  count_reg;
    logic              out_valid_reg;
    logic [TAG_W-1:0]  out_tag_reg;
    logic [OPC_W-1:0]  out_opcode_reg;
    logic [IMM_W-1:0]  out_imm_reg;
    logic [DATA_W-1:0] out_val1_reg;
    logic [DATA_W-1:0] out_val2_reg;

    logic [TAG_W-1:0]  sel_tag;
    logic [OPC_W-1:0]  sel_opcode;
    logic [IMM_W-1:0]  sel_imm;
    logic [DATA_W-1:0] sel_val1;
    logic [DATA_W-1:0] sel_val2;

    // Slots freed this cycle are still counted, so they cannot be refilled
    // until the next cycle.
    assign in_ready = (count_reg < CNT_W'(DEPTH)) && !flush;
    assign in_fire  = in_valid && in_ready;

    // Lowest clear bit of the valid vector.
    assign free_onehot = ~ent_valid & (ent_valid + DEPTH'(1));
    assign load_vec    = free_onehot & {DEPTH{in_fire}};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            rs_entry #(
                .NUM_CDB (NUM_CDB),
                .TAG_W   (TAG_W),
                .DATA_W  (DATA_W),
                .OPC_W   (OPC_W),
                .IMM_W   (IMM_W)
            ) u_entry (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush),
                .load        (load_vec[gi]),
                .issue       (issue_vec[gi]),
                .in_tag      (in_tag),
                .in_opcode   (in_opcode),
                .in_imm      (in_imm),
                .in_src1_tag (in_src1_tag),
                .in_src2_tag (in_src2_tag),
                .in_src1_val (in_src1_val),
                .in_src2_val (in_src2_val),
                .in_src1_rdy (in_src1_rdy),
                .in_src2_rdy (in_src2_rdy),
                .cdb_valid   (cdb_valid),
                .cdb_tag     (cdb_tag),
                .cdb_data    (cdb_data),
                .valid       (ent_valid[gi]),
                .ready       (ent_ready[gi]),
                .tag         (ent_tag[gi]),
                .opcode      (ent_opcode[gi]),
                .imm         (ent_imm[gi]),
                .val1        (ent_val1[gi]),
                .val2        (ent_val2[gi])
            );
        end
    endgenerate

    // A newly written slot becomes younger than every other slot: its row is
    // cleared and its column set. Stale bits of empty slots are harmless
    // because selection only looks at ready slots and a refill rewrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_vec[i]) begin
                    older_reg[i] <= '0;
                end else begin
                    older_reg[i] <= older_reg[i] | load_vec;
                end
            end
        end
    end

    // A ready slot is granted when no other ready slot is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ent_ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ent_ready[j] && older_reg[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    assign issue_fire = (|ent_ready) && (!out_valid_reg || out_ready) && !flush;
    assign issue_vec  = grant & {DEPTH{issue_fire}};

    // AND-OR mux; grant is one-hot whenever any slot is ready.
    always_comb begin
        sel_tag    = '0;
        sel_opcode = '0;
        sel_imm    = '0;
        sel_val1   = '0;
        sel_val2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_tag    = sel_tag    | ent_tag[i];
                sel_opcode = sel_opcode | ent_opcode[i];
                sel_imm    = sel_imm    | ent_imm[i];
                sel_val1   = sel_val1   | ent_val1[i];
                sel_val2   = sel_val2   | ent_val2[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(in_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_tag_reg    <= '0;
            out_opcode_reg <= '0;
            out_imm_reg    <= '0;
            out_val1_reg   <= '0;
            out_val2_reg   <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (issue_fire) begin
            out_valid_reg  <= 1'b1;
            out_tag_reg    <= sel_tag;
            out_opcode_reg <= sel_opcode;
            out_imm_reg    <= sel_imm;
            out_val1_reg   <= sel_val1;
            out_val2_reg   <= sel_val2;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_tag    = out_tag_reg;
    assign out_opcode = out_opcode_reg;
    assign out_imm    = out_imm_reg;
    assign out_val1   = out_val1_reg;
    assign out_val2   = out_val2_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_param_res_station.sv
// -----------------------------------------------------------------------------
// tb_param_res_station -- directed self-checking bench for param_res_station
// at default parameters. Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, away from the next edge.
// -----------------------------------------------------------------------------
module tb_param_res_station;

    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 16;
    localparam int OPC_W   = 4;
    localparam int IMM_W   = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [TAG_W-1:0]          in_tag;
    logic [OPC_W-1:0]          in_opcode;
    logic [IMM_W-1:0]          in_imm;
    logic [TAG_W-1:0]          in_src1_tag;
    logic [TAG_W-1:0]          in_src2_tag;
    logic [DATA_W-1:0]         in_src1_val;
    logic [DATA_W-1:0]         in_src2_val;
    logic                      in_src1_rdy;
    logic                      in_src2_rdy;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [TAG_W-1:0]          out_tag;
    logic [OPC_W-1:0]          out_opcode;
    logic [IMM_W-1:0]          out_imm;
    logic [DATA_W-1:0]         out_val1;
    logic [DATA_W-1:0]         out_val2;
    logic [CNT_W-1:0]          count;

    int tests_run = 0;
    int tests_failed = 0;

    param_res_station #(
        .DEPTH   (DEPTH),
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .OPC_W   (OPC_W),
        .IMM_W   (IMM_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .in_opcode   (in_opcode),
        .in_imm      (in_imm),
        .in_src1_tag (in_src1_tag),
        .in_src2_tag (in_src2_tag),
        .in_src1_val (in_src1_val),
        .in_src2_val (in_src2_val),
        .in_src1_rdy (in_src1_rdy),
        .in_src2_rdy (in_src2_rdy),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tag     (out_tag),
        .out_opcode  (out_opcode),
        .out_imm     (out_imm),
        .out_val1    (out_val1),
        .out_val2    (out_val2),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Present one instruction for one cycle.
    task automatic insert(input logic [TAG_W-1:0] t,
                          input logic [TAG_W-1:0] s1t, input logic [DATA_W-1:0] s1v, input logic s1r,
                          input logic [TAG_W-1:0] s2t, input logic [DATA_W-1:0] s2v, input logic s2r);
        in_valid    = 1'b1;
        in_tag      = t;
        in_opcode   = t;
        in_imm      = {4'h0, t};
        in_src1_tag = s1t;
        in_src1_val = s1v;
        in_src1_rdy = s1r;
        in_src2_tag = s2t;
        in_src2_val = s2v;
        in_src2_rdy = s2r;
        tick();
        in_valid = 1'b0;
    endtask

    // Ready instruction whose operand values are derived from its tag.
    task automatic insert_rdy(input logic [TAG_W-1:0] t);
        insert(t, 4'h0, 16'h1000 + 16'(t), 1'b1, 4'h0, 16'h2000 + 16'(t), 1'b1);
    endtask

    task automatic cdb_idle();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_tag      = '0;
        in_opcode   = '0;
        in_imm      = '0;
        in_src1_tag = '0;
        in_src2_tag = '0;
        in_src1_val = '0;
        in_src2_val = '0;
        in_src1_rdy = 1'b0;
        in_src2_rdy = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        cdb_idle();

        // ---- reset state ----
        #1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        // ---- fill: first instruction moves into the output register, so
        //      five inserts are needed to occupy all four slots ----
        out_ready = 1'b0;
        insert_rdy(4'd1);
        insert_rdy(4'd2);
        insert_rdy(4'd3);
        insert_rdy(4'd4);
        insert_rdy(4'd5);
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_out_tag", out_tag, 1);
        check("fill_out_val1", out_val1, 16'h1001);
        insert_rdy(4'd6);
        check("fill_reject_count", count, 4);
        check("fill_hold_tag", out_tag, 1);

        // ---- drain in age order: tag 2 sits in slot 1, tag 3 in slot 0 ----
        out_ready = 1'b1;
        tick();
        check("drain_tag_a", out_tag, 2);
        check("drain_count", count, 3);
        tick();
        check("drain_tag_b", out_tag, 3);
        tick();
        check("drain_tag_c", out_tag, 4);
        tick();
        check("drain_tag_d", out_tag, 5);
        check("drain_val2", out_val2, 16'h2005);
        tick();
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_count", count, 0);

        // ---- wakeup through CDB channel 2 ----
        insert(4'd3, 4'd7, 16'h0000, 1'b0, 4'd0, 16'h0022, 1'b1);
        cdb_valid = 4'b0100;
        cdb_tag   = 16'h0700;
        cdb_data  = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
        tick();
        cdb_idle();
        check("wake_not_yet", out_valid, 0);
        tick();
        check("wake_out_valid", out_valid, 1);
        check("wake_out_tag", out_tag, 3);
        check("wake_out_val1", out_val1, 16'h1234);
        check("wake_out_val2", out_val2, 16'h0022);
        tick();
        check("wake_drop_valid", out_valid, 0);

        // ---- age: tag 5 waits, tag 6 ready, then tag 5 woken ----
        insert(4'd5, 4'd8, 16'h0000, 1'b0, 4'd0, 16'h0055, 1'b1);
        insert(4'd6, 4'd0, 16'h0066, 1'b1, 4'd0, 16'h0067, 1'b1);
        cdb_valid = 4'b0001;
        cdb_tag   = 16'h0008;
        cdb_data  = {48'h0, 16'h0505};
        tick();
        cdb_idle();
        check("age_first_tag", out_tag, 6);
        tick();
        check("age_second_tag", out_tag, 5);
        check("age_second_val1", out_val1, 16'h0505);
        tick();

        // ---- two channels match one operand: lowest channel wins ----
        insert(4'd1, 4'd0, 16'h0011, 1'b1, 4'd2, 16'h0000, 1'b0);
        cdb_valid = 4'b1011;
        cdb_tag   = 16'h2025;
        cdb_data  = {16'hBBBB, 16'h0000, 16'hAAAA, 16'hCCCC};
        tick();
        cdb_idle();
        tick();
        check("multi_out_tag", out_tag, 1);
        check("multi_out_val2", out_val2, 16'hAAAA);
        tick();

        // ---- flush with three entries and a held output ----
        out_ready = 1'b0;
        insert_rdy(4'd1);
        insert_rdy(4'd2);
        insert_rdy(4'd3);
        insert_rdy(4'd4);
        check("flush_pre_count", count, 3);
        check("flush_pre_valid", out_valid, 1);
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_tag      = 4'd9;
        in_src1_rdy = 1'b1;
        in_src2_rdy = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        tick();
        check("flush_stays_empty", count, 0);

        // ---- insertion while CDB broadcasts the missing operand ----
        out_ready = 1'b1;
        cdb_valid = 4'b0001;
        cdb_tag   = 16'h0009;
        cdb_data  = {48'h0, 16'h00FF};
        insert(4'd4, 4'd0, 16'h0044, 1'b1, 4'd9, 16'h0000, 1'b0);
        cdb_idle();
        tick();
`ifdef RS_CDB_BYPASS_EN
        check("bypass_out_valid", out_valid, 1);
        check("bypass_out_val2", out_val2, 16'h00FF);
        check("bypass_count", count, 0);
`else
        check("nobypass_out_valid", out_valid, 0);
        check("nobypass_count", count, 1);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("bypass_clean", count, 0);

        // ---- reset in the middle of a handshake ----
        out_ready = 1'b0;
        insert_rdy(4'd7);
        insert_rdy(4'd8);
        check("midrst_pre_valid", out_valid, 1);
        in_valid = 1'b1;
        in_tag   = 4'd9;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_count", count, 0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        tick();
        check("midrst_after_count", count, 0);
        check("midrst_after_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
